uart_block_loader: RTL

UART_BLOCK_LOADER -- requirements
Module: uart_block_loader

---
 rtl/uart_sha_pkg.sv | 8 +
 rtl/byte_timeout.sv | 18 +
 rtl/uart_block_loader.sv | 81 ++++++++
 3 files changed

// File: rtl/uart_sha_pkg.sv
// uart_sha_pkg: shared state encoding and framing constants for the UART-to-SHA block loader.
package uart_sha_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, WAIT_DONE} state_t;
    localparam int BLOCK_BYTES = 64;
    localparam logic [3:0] DEFAULT_CMD_TAG = 4'hA;
    localparam int FIRST_BIT = 0;
    localparam int LAST_BIT = 1;
endpackage

// File: rtl/byte_timeout.sv
// byte_timeout: inter-byte watchdog; expired flags the cycle the count reaches TIMEOUT_CYCLES-1 with no clear.
module byte_timeout #(
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable) cnt <= cnt + W'(1);
    assign expired = enable && !clear && cnt == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/uart_block_loader.sv
// uart_block_loader: assembles 64 UART bytes after a command byte into a 512-bit block for a SHA core.
module uart_block_loader
    import uart_sha_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter logic [3:0] CMD_TAG = DEFAULT_CMD_TAG
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [511:0] block,
    output logic         block_valid,
    input  logic         block_ready,
    output logic         first_blk,
    output logic         last_blk,
    input  logic         core_done,
    output logic         busy,
    output logic         err_cmd,
    output logic         err_timeout,
    output logic         overrun
);
    localparam logic [5:0] LAST_IDX = 6'(BLOCK_BYTES - 1);
    state_t state, state_n;
    logic [5:0] byte_cnt;
    logic expired, cmd_ok;
    assign cmd_ok = rx_data[7:4] == CMD_TAG;
    // The timer only runs in LOAD; holding it clear elsewhere also covers the clear-on-entry case.
    byte_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk(clk),
        .rst(rst),
        .clear(state != LOAD || rx_valid),
        .enable(state == LOAD),
        .expired(expired)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    // Error pulses are combinational so they land on the offending cycle; rst masks a stray strobe in reset.
    always_comb begin
        state_n = state;
        err_cmd = 1'b0;
        err_timeout = 1'b0;
        overrun = 1'b0;
        busy = state != IDLE;
        block_valid = state == ISSUE;
        case (state)
            IDLE: begin
                state_n = rx_valid && cmd_ok ? LOAD : IDLE;
                err_cmd = rx_valid && !cmd_ok && !rst;
            end
            LOAD: begin
                state_n = rx_valid ? (byte_cnt == LAST_IDX ? ISSUE : LOAD) : (expired ? IDLE : LOAD);
                err_timeout = expired;
            end
            ISSUE: begin
                state_n = block_ready ? WAIT_DONE : ISSUE;
                overrun = rx_valid;
            end
            WAIT_DONE: begin
                state_n = core_done ? IDLE : WAIT_DONE;
                overrun = rx_valid;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            byte_cnt <= '0;
            block <= '0;
            first_blk <= 1'b0;
            last_blk <= 1'b0;
        end else if (rx_valid && state == IDLE && cmd_ok) begin
            byte_cnt <= '0;
            first_blk <= rx_data[FIRST_BIT];
            last_blk <= rx_data[LAST_BIT];
        end else if (rx_valid && state == LOAD) begin
            block[{LAST_IDX - byte_cnt, 3'b000} +: 8] <= rx_data;
            byte_cnt <= byte_cnt + 6'd1;
        end
endmodule
